// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the multi-channel debounce
// filter (debounce_multi / debounce_channel).
//   DEFAULT_N        default channel count
//   DEFAULT_WAIT_CLK default number of consecutive disagreeing samples
//   clog2()          constant function used to size the stability counter
package debounce_pkg;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_WAIT_CLK = 100;

  // ceil(log2(v)), never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: single-bit debounce filter with registered rise/fall
// event pulses. One instance per channel of debounce_multi.
// Optional macro DEBOUNCE_MULTI_SYNC_EN inserts a 2-flop synchroniser ahead
// of the filter (adds two edges of latency).
// Ports:
//   clk     in   system clock, posedge
//   rst     in   asynchronous active-high reset
//   sig_in  in   raw input bit
//   debc    out  debounced level (registered)
//   rise    out  one-cycle pulse on debc 0->1 (registered)
//   fall    out  one-cycle pulse on debc 1->0 (registered)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   WAIT_CLK  = DEFAULT_WAIT_CLK,
  parameter int   CNT_W     = clog2(DEFAULT_WAIT_CLK + 1),
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic debc,
  output logic rise,
  output logic fall
);

  // Last count value before the output is allowed to follow the input.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CLK - 1);

  logic s;

`ifdef DEBOUNCE_MULTI_SYNC_EN
  // Two-stage synchroniser; resets to the filter's reset level so that
  // reset release never looks like an input transition.
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], sig_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RESET_VAL}};
    else     sync_q <= sync_d;
  end

  assign s = sync_q[1];
`else
  assign s = sig_in;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             debc_q, debc_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    debc_d = debc_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == debc_q) begin
      // Any agreeing sample discards all accumulated credit.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      debc_d = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      debc_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debc_q <= debc_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign debc = debc_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel debounce filter with per-channel stability
// counters and registered rise/fall event pulses. Channels are independent
// instances of debounce_channel.
// Optional macro DEBOUNCE_MULTI_SYNC_EN adds a 2-flop synchroniser per
// channel (latency WAIT_CLK+2 edges instead of WAIT_CLK).
// Parameters:
//   N          channel count (>=1)
//   WAIT_CLK   consecutive disagreeing samples before output follows (>=1)
//   RESET_VAL  per-channel debounced level during/after reset
// Ports:
//   clk       in   [1]   system clock, posedge
//   rst       in   [1]   asynchronous active-high reset
//   signal    in   [N]   raw inputs
//   debc_sig  out  [N]   debounced levels (registered)
//   rise      out  [N]   one-cycle 0->1 event pulses (registered)
//   fall      out  [N]   one-cycle 1->0 event pulses (registered)
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int           N         = DEFAULT_N,
  parameter int           WAIT_CLK  = DEFAULT_WAIT_CLK,
  parameter logic [N-1:0] RESET_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] signal,
  output logic [N-1:0] debc_sig,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  // Derived from WAIT_CLK so the counter can hold WAIT_CLK-1 without wrapping.
  localparam int CNT_W = clog2(WAIT_CLK + 1);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .WAIT_CLK  (WAIT_CLK),
      .CNT_W     (CNT_W),
      .RESET_VAL (RESET_VAL[g])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .sig_in (signal[g]),
      .debc   (debc_sig[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed + randomized bench for debounce_multi.
// Reference model: a channel's debounced level flips once the most recent
// WAIT_CLK filter samples all disagree with it; the sample window is cleared
// by reset.
module tb_debounce_multi;

  localparam int           N        = 2;
  localparam int           WAIT_CLK = 4;
  localparam logic [N-1:0] RST_V    = 2'b01;
`ifdef DEBOUNCE_MULTI_SYNC_EN
  localparam int           LAT      = WAIT_CLK + 2;
`else
  localparam int           LAT      = WAIT_CLK;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] signal;
  logic [N-1:0] debc_sig, rise, fall;

  debounce_multi #(
    .N         (N),
    .WAIT_CLK  (WAIT_CLK),
    .RESET_VAL (RST_V)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .signal   (signal),
    .debc_sig (debc_sig),
    .rise     (rise),
    .fall     (fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [N-1:0] m_debc, m_rise, m_fall;
  logic [N-1:0] hist[$];   // most recent filter samples, oldest first
  logic [N-1:0] sq[$];     // synchroniser delay line

  task automatic model_reset();
    m_debc = RST_V;
    m_rise = '0;
    m_fall = '0;
    hist.delete();
    sq.delete();
    sq.push_back(RST_V);
    sq.push_back(RST_V);
  endtask

  task automatic model_edge(input logic [N-1:0] v);
    logic [N-1:0] s;
    logic         all_diff;
`ifdef DEBOUNCE_MULTI_SYNC_EN
    sq.push_back(v);
    s = sq.pop_front();
`else
    s = v;
`endif
    hist.push_back(s);
    if (hist.size() > WAIT_CLK) void'(hist.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) begin
      all_diff = (hist.size() == WAIT_CLK);
      foreach (hist[k]) if (hist[k][i] == m_debc[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_rise[i] = ~m_debc[i];
        m_fall[i] = m_debc[i];
        m_debc[i] = ~m_debc[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".debc"}, debc_sig, m_debc);
    chk({tag, ".rise"}, rise, m_rise);
    chk({tag, ".fall"}, fall, m_fall);
    chk({tag, ".excl"}, rise & fall, '0);
  endtask

  // Drive v ahead of the next posedge, then compare on the following negedge.
  task automatic tick(input logic [N-1:0] v, input string tag);
    signal = v;
    @(posedge clk);
    if (!rst) model_edge(v);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous assert away from any edge, hold, release on a negedge.
  task automatic do_reset(input logic [N-1:0] v, input int cycles);
    signal = v;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  logic [N-1:0] cur;

  initial begin
    signal = 2'b10;
    rst    = 1'b0;
    model_reset();
    #2;

    // Reset with inputs disagreeing with RESET_VAL, then debounce after release
    do_reset(2'b10, 3);
    chk("rst_lvl", debc_sig, 2'b01);
    for (int k = 1; k <= LAT; k++) begin
      tick(2'b10, "rst_rel");
      if (k < LAT) begin
        chk("rst_rel_hold", debc_sig, 2'b01);
        chk("rst_rel_nopulse", rise | fall, 2'b00);
      end else begin
        chk("rst_rel_debc", debc_sig, 2'b10);
        chk("rst_rel_rise", rise, 2'b10);
        chk("rst_rel_fall", fall, 2'b01);
      end
    end
    tick(2'b10, "rst_rel_after");
    chk("rst_pulse_1cyc", rise | fall, 2'b00);

    // Clean edge on channel 0
    repeat (LAT + 1) tick(2'b00, "settle");
    for (int k = 1; k <= LAT; k++) begin
      tick(2'b01, "clean");
      if (k == LAT) begin
        chk("clean_debc", debc_sig, 2'b01);
        chk("clean_rise", rise, 2'b01);
      end else begin
        chk("clean_hold", debc_sig, 2'b00);
      end
    end
    tick(2'b01, "clean_after");
    chk("clean_1cyc", rise, 2'b00);

    // Glitch rejection: high 3, low 1, high 4 (+sync delay)
    repeat (LAT + 1) tick(2'b00, "settle");
    repeat (3) tick(2'b01, "glitch_a");
    tick(2'b00, "glitch_low");
    repeat (LAT - WAIT_CLK) tick(2'b01, "glitch_b");
    repeat (WAIT_CLK - 1) tick(2'b01, "glitch_b");
    chk("glitch_nocredit", debc_sig, 2'b00);
    tick(2'b01, "glitch_b_last");
    chk("glitch_rise", debc_sig, 2'b01);

    // Simultaneous and staggered toggles
    repeat (LAT + 1) tick(2'b00, "settle");
    repeat (LAT) tick(2'b11, "simul");
    chk("simul_rise", rise, 2'b11);
    repeat (LAT + 1) tick(2'b00, "settle");
    repeat (2) tick(2'b01, "stagger");
    repeat (LAT + 2) tick(2'b11, "stagger");

    // Reset mid-count on channel 1 (reset level 0 there)
    repeat (LAT + 1) tick(2'b00, "settle");
    repeat (3) tick(2'b10, "midcnt");
    do_reset(2'b10, 2);
    for (int k = 1; k <= LAT; k++) begin
      tick(2'b10, "midcnt_rel");
      if (k < LAT) chk("midcnt_nopulse", rise, 2'b00);
    end
    chk("midcnt_rise", rise, 2'b10);

    // Randomized: sparse toggles, occasional glitches and resets
    cur = 2'b00;
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 149) == 0) do_reset(cur, $urandom_range(1, 3));
      else tick(cur, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
